// File: rtl/commit_trace_if.sv
// commit_trace_if
//   Bundles the two channels of the commit trace port:
//   - retire channel (core -> trace port): ret_* event fields, with stall_out
//     returned to the core as back-pressure.
//   - trace channel (trace port -> sink): trc_* head record, trc_valid/trc_ready.
//
// Handshake rules:
//   retire: an event is taken on a rising edge where ret_valid=1, stall_out=0
//           and the port is still accepting (no halt seen). While stall_out=1
//           the core must hold the event and keep ret_valid asserted.
//   trace:  a record moves on a rising edge where trc_valid=1 and trc_ready=1.
//           While trc_valid=1 and trc_ready=0 all trc_* fields hold steady.
//
// Modports: master = core/sink side, slave = trace port.
interface commit_trace_if;
  logic        ret_valid;
  logic [15:0] ret_pc;
  logic [15:0] ret_inst;
  logic        ret_regwrite;
  logic [2:0]  ret_wreg;
  logic [15:0] ret_wdata;
  logic        ret_memread;
  logic        ret_memwrite;
  logic [15:0] ret_memaddr;
  logic [15:0] ret_memdata;
  logic        ret_halt;
  logic        stall_out;

  logic        trc_valid;
  logic        trc_ready;
  logic [31:0] trc_inum;
  logic [2:0]  trc_kind;
  logic [15:0] trc_pc;
  logic [2:0]  trc_reg;
  logic [15:0] trc_regval;
  logic [15:0] trc_addr;
  logic [15:0] trc_memval;

  modport master (
    output ret_valid, ret_pc, ret_inst, ret_regwrite, ret_wreg, ret_wdata,
           ret_memread, ret_memwrite, ret_memaddr, ret_memdata, ret_halt,
           trc_ready,
    input  stall_out, trc_valid, trc_inum, trc_kind, trc_pc, trc_reg,
           trc_regval, trc_addr, trc_memval
  );

  modport slave (
    input  ret_valid, ret_pc, ret_inst, ret_regwrite, ret_wreg, ret_wdata,
           ret_memread, ret_memwrite, ret_memaddr, ret_memdata, ret_halt,
           trc_ready,
    output stall_out, trc_valid, trc_inum, trc_kind, trc_pc, trc_reg,
           trc_regval, trc_addr, trc_memval
  );
endinterface

// File: rtl/commit_trace_port.sv
// commit_trace_port
//   Producer side of the per-instruction commit trace. Classifies each
//   retirement event into a record kind, tags it with a sequential
//   instruction number, buffers it in a DEPTH-entry FIFO and streams it out.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   bus (slave)        retire channel in, trace channel out (commit_trace_if)
//   cycle_count        cycles since reset, frozen once the halt has drained
//   inst_count         records enqueued since reset
//   halted             the halt record has left the FIFO
//   dbg_state_o        current FSM state (RUN/DRAIN/DONE)
//   dbg_last_inst_o    instruction word of the most recently enqueued event
module commit_trace_port #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  commit_trace_if.slave bus,
  output logic [31:0]   cycle_count,
  output logic [31:0]   inst_count,
  output logic          halted,
  output logic [1:0]    dbg_state_o,
  output logic [15:0]   dbg_last_inst_o
);

  localparam logic [2:0] K_NOP  = 3'd0;
  localparam logic [2:0] K_REG  = 3'd1;
  localparam logic [2:0] K_LD   = 3'd2;
  localparam logic [2:0] K_ST   = 3'd3;
  localparam logic [2:0] K_STU  = 3'd4;
  localparam logic [2:0] K_HALT = 3'd5;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      inst_q, inst_d;
  logic [15:0]      last_inst_q, last_inst_d;

  // Record storage; contents are only observable through the head when the
  // FIFO is non-empty, so it carries no reset.
  logic [31:0] inum_mem   [DEPTH];
  logic [2:0]  kind_mem   [DEPTH];
  logic [15:0] pc_mem     [DEPTH];
  logic [2:0]  reg_mem    [DEPTH];
  logic [15:0] regval_mem [DEPTH];
  logic [15:0] addr_mem   [DEPTH];
  logic [15:0] memval_mem [DEPTH];

  logic        full;
  logic        not_empty;
  logic        enq;
  logic        deq;

  logic [2:0]  in_kind;
  logic [2:0]  in_reg;
  logic [15:0] in_regval;
  logic [15:0] in_addr;
  logic [15:0] in_memval;

  // Classification: first match wins. Fields a kind does not carry are
  // stored as zero so the sink never sees stale bus values.
  always_comb begin
    in_kind   = K_NOP;
    in_reg    = '0;
    in_regval = '0;
    in_addr   = '0;
    in_memval = '0;
    if (bus.ret_regwrite && bus.ret_memwrite) begin
      in_kind   = K_STU;
      in_reg    = bus.ret_wreg;
      in_regval = bus.ret_wdata;
      in_addr   = bus.ret_memaddr;
      in_memval = bus.ret_memdata;
    end else if (bus.ret_regwrite && bus.ret_memread) begin
      in_kind   = K_LD;
      in_reg    = bus.ret_wreg;
      in_regval = bus.ret_wdata;
      in_addr   = bus.ret_memaddr;
    end else if (bus.ret_regwrite) begin
      in_kind   = K_REG;
      in_reg    = bus.ret_wreg;
      in_regval = bus.ret_wdata;
    end else if (bus.ret_halt) begin
      in_kind   = K_HALT;
    end else if (bus.ret_memwrite) begin
      in_kind   = K_ST;
      in_addr   = bus.ret_memaddr;
      in_memval = bus.ret_memdata;
    end
  end

  // Full blocks enqueue even when a dequeue happens in the same cycle; this
  // keeps stall_out a pure function of registered occupancy.
  assign full      = (count_q == FULL_CNT);
  assign not_empty = (count_q != '0);
  assign enq       = bus.ret_valid && !full && (state_q == S_RUN);
  assign deq       = not_empty && bus.trc_ready;

  assign bus.stall_out = full;
  assign bus.trc_valid = not_empty;

  // Head outputs read zero while empty, which also gives the zero reset
  // values without clearing the storage array.
  assign bus.trc_inum   = not_empty ? inum_mem[rd_ptr_q]   : '0;
  assign bus.trc_kind   = not_empty ? kind_mem[rd_ptr_q]   : '0;
  assign bus.trc_pc     = not_empty ? pc_mem[rd_ptr_q]     : '0;
  assign bus.trc_reg    = not_empty ? reg_mem[rd_ptr_q]    : '0;
  assign bus.trc_regval = not_empty ? regval_mem[rd_ptr_q] : '0;
  assign bus.trc_addr   = not_empty ? addr_mem[rd_ptr_q]   : '0;
  assign bus.trc_memval = not_empty ? memval_mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (enq) begin
      inum_mem[wr_ptr_q]   <= inst_q;
      kind_mem[wr_ptr_q]   <= in_kind;
      pc_mem[wr_ptr_q]     <= bus.ret_pc;
      reg_mem[wr_ptr_q]    <= in_reg;
      regval_mem[wr_ptr_q] <= in_regval;
      addr_mem[wr_ptr_q]   <= in_addr;
      memval_mem[wr_ptr_q] <= in_memval;
    end
  end

  // Pointers, occupancy and counters.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    inst_d      = inst_q;
    cycle_d     = cycle_q;
    last_inst_d = last_inst_q;

    if (enq) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      inst_d      = inst_q + 32'd1;
      last_inst_d = bus.ret_inst;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (state_q != S_DONE) begin
      cycle_d = cycle_q + 32'd1;
    end
  end

  // FSM: RUN accepts events; once a halt is enqueued DRAIN lets the FIFO
  // empty; DONE is entered as the halt record leaves and holds until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (enq && (in_kind == K_HALT)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (deq && (kind_mem[rd_ptr_q] == K_HALT)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cycle_q     <= '0;
      inst_q      <= '0;
      last_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cycle_q     <= cycle_d;
      inst_q      <= inst_d;
      last_inst_q <= last_inst_d;
    end
  end

  assign cycle_count     = cycle_q;
  assign inst_count      = inst_q;
  assign halted          = (state_q == S_DONE);
  assign dbg_state_o     = state_q;
  assign dbg_last_inst_o = last_inst_q;

endmodule
